instr_fetch: RTL and testbench

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/instr_fetch.sv | 122 ++++++++++++
 tb/tb_instr_fetch.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// Instruction fetch stage: requests a word from imem, holds it in IR
// until retire, then computes the next fetch address from PC_sel.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic [1:0]  PC_sel,
  input  logic        br_taken,
  input  logic [31:0] rs_data,
  output logic [31:0] instr,
  output logic [5:0]  opcode,
  output logic [5:0]  func,
  output logic        ir_valid,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic [31:0] instret,
  output logic        err
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    ERR   = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instret_q, instret_d;

  logic        retire;
  logic        misaligned;
  logic [31:0] pc4;
  logic [31:0] br_off;
  logic [31:0] target;

  assign pc4    = pc_q + 32'd4;
  assign br_off = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
  assign retire = (state_q == HOLD) && !stall;

  always_comb begin
    target = pc4;
    unique case (PC_sel)
      2'b00: target = pc4;
      2'b01: target = br_taken ? (pc4 + br_off) : pc4;
      2'b10: target = {pc4[31:28], instr_q[25:0], 2'b00};
      2'b11: target = rs_data;
    endcase
  end

  // only a register target can land off a word boundary
  assign misaligned = |target[1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= FETCH;
      fetch_pc_q <= RESET_PC;
      instr_q    <= '0;
      pc_q       <= RESET_PC;
      instret_q  <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      instr_q    <= instr_d;
      pc_q       <= pc_d;
      instret_q  <= instret_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      FETCH:   if (imem_ack) state_d = HOLD;
      HOLD:    if (!stall) state_d = misaligned ? ERR : FETCH;
      ERR:     state_d = ERR;
      default: state_d = FETCH;
    endcase
  end

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    instr_d    = instr_q;
    pc_d       = pc_q;
    instret_d  = instret_q;
    if ((state_q == FETCH) && imem_ack) begin
      instr_d = imem_rdata;
      pc_d    = fetch_pc_q;
    end
    if (retire) begin
      fetch_pc_d = target;
      instret_d  = instret_q + 32'd1;
    end
  end

  always_comb begin
    imem_req = 1'b0;
    ir_valid = 1'b0;
    err      = 1'b0;
    unique case (state_q)
      FETCH:   imem_req = 1'b1;
      HOLD:    ir_valid = 1'b1;
      ERR:     err      = 1'b1;
      default: imem_req = 1'b0;
    endcase
  end

  assign imem_addr = fetch_pc_q;
  assign instr     = instr_q;
  assign opcode    = instr_q[31:26];
  assign func      = instr_q[5:0];
  assign pc        = pc_q;
  assign pc_plus4  = pc4;
  assign instret   = instret_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: vector table of fetch/retire
// transactions plus hand-written reset and error sequences.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        stall;
  logic [1:0]  PC_sel;
  logic        br_taken;
  logic [31:0] rs_data;
  logic [31:0] instr;
  logic [5:0]  opcode;
  logic [5:0]  func;
  logic        ir_valid;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] instret;
  logic        err;

  instr_fetch #(.RESET_PC(32'h0000_3000)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .stall(stall), .PC_sel(PC_sel),
    .br_taken(br_taken), .rs_data(rs_data),
    .instr(instr), .opcode(opcode), .func(func),
    .ir_valid(ir_valid), .pc(pc), .pc_plus4(pc_plus4),
    .instret(instret), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] rdata;
    int          delay;
    int          stalls;
    logic [1:0]  sel;
    logic        br;
    logic [31:0] rs;
    logic [31:0] next;
    logic [31:0] p4;
    logic        to_err;
  } vec_t;

  vec_t vecs[11];
  int   n_tests = 0;
  int   n_fail  = 0;
  logic [31:0] cnt = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    string t;
    t = $sformatf("v%0d", idx);
    chk({t, " req"}, {31'd0, imem_req}, 32'd1);
    chk({t, " addr"}, imem_addr, v.addr);
    chk({t, " irv_fetch"}, {31'd0, ir_valid}, 32'd0);
    for (int i = 0; i < v.delay; i++) begin
      imem_ack = 1'b0;
      imem_rdata = 32'hBAD0_0000;
      step();
      chk({t, " req_hold"}, {31'd0, imem_req}, 32'd1);
      chk({t, " addr_hold"}, imem_addr, v.addr);
    end
    imem_ack = 1'b1;
    imem_rdata = v.rdata;
    step();
    imem_ack = 1'b0;
    chk({t, " irv"}, {31'd0, ir_valid}, 32'd1);
    chk({t, " req_low"}, {31'd0, imem_req}, 32'd0);
    chk({t, " instr"}, instr, v.rdata);
    chk({t, " pc"}, pc, v.addr);
    chk({t, " pc4"}, pc_plus4, v.p4);
    chk({t, " op"}, {26'd0, opcode}, {26'd0, v.rdata[31:26]});
    chk({t, " func"}, {26'd0, func}, {26'd0, v.rdata[5:0]});
    chk({t, " instret_hold"}, instret, cnt);
    // ack and data during HOLD must be ignored
    for (int i = 0; i < v.stalls; i++) begin
      stall = 1'b1;
      imem_ack = 1'b1;
      imem_rdata = ~v.rdata;
      step();
      chk({t, " st_instr"}, instr, v.rdata);
      chk({t, " st_pc"}, pc, v.addr);
      chk({t, " st_irv"}, {31'd0, ir_valid}, 32'd1);
      chk({t, " st_instret"}, instret, cnt);
    end
    stall = 1'b0;
    imem_ack = 1'b0;
    PC_sel = v.sel;
    br_taken = v.br;
    rs_data = v.rs;
    step();
    cnt++;
    chk({t, " instret"}, instret, cnt);
    chk({t, " irv_after"}, {31'd0, ir_valid}, 32'd0);
    if (v.to_err) begin
      chk({t, " err"}, {31'd0, err}, 32'd1);
      chk({t, " req_err"}, {31'd0, imem_req}, 32'd0);
    end else begin
      chk({t, " err0"}, {31'd0, err}, 32'd0);
      chk({t, " req_next"}, {31'd0, imem_req}, 32'd1);
      chk({t, " next"}, imem_addr, v.next);
    end
    PC_sel = 2'b00;
    br_taken = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "timeout");
  end

  initial begin
    //          addr          rdata         dly stl sel br rs            next          p4           err
    vecs[0]  = '{32'h0000_3000, 32'h3408_0005, 2, 0, 2'b00, 1'b0, 32'h0,
                 32'h0000_3004, 32'h0000_3004, 1'b0};
    vecs[1]  = '{32'h0000_3004, 32'h0800_0C04, 0, 0, 2'b10, 1'b0, 32'h0,
                 32'h0000_3010, 32'h0000_3008, 1'b0};
    vecs[2]  = '{32'h0000_3010, 32'h1000_FFFE, 1, 2, 2'b01, 1'b1, 32'h0,
                 32'h0000_300C, 32'h0000_3014, 1'b0};
    vecs[3]  = '{32'h0000_300C, 32'h1000_0001, 0, 0, 2'b01, 1'b0, 32'h0,
                 32'h0000_3010, 32'h0000_3010, 1'b0};
    vecs[4]  = '{32'h0000_3010, 32'h1000_FFFE, 0, 5, 2'b01, 1'b0, 32'h0,
                 32'h0000_3014, 32'h0000_3014, 1'b0};
    vecs[5]  = '{32'h0000_3014, 32'h0000_0008, 1, 0, 2'b11, 1'b0,
                 32'h0000_3000, 32'h0000_3000, 32'h0000_3018, 1'b0};
    vecs[6]  = '{32'h0000_3000, 32'h0800_0C10, 0, 1, 2'b10, 1'b0, 32'h0,
                 32'h0000_3040, 32'h0000_3004, 1'b0};
    vecs[7]  = '{32'h0000_3040, 32'h0000_0008, 0, 0, 2'b11, 1'b0,
                 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0000_3044, 1'b0};
    vecs[8]  = '{32'hFFFF_FFFC, 32'h0000_0020, 0, 0, 2'b00, 1'b0, 32'h0,
                 32'h0000_0000, 32'h0000_0000, 1'b0};
    vecs[9]  = '{32'h0000_0000, 32'h1000_0003, 0, 0, 2'b01, 1'b1, 32'h0,
                 32'h0000_0010, 32'h0000_0004, 1'b0};
    vecs[10] = '{32'h0000_0010, 32'h0000_0008, 0, 0, 2'b11, 1'b0,
                 32'h0000_3021, 32'h0, 32'h0000_0014, 1'b1};

    rst = 1'b1;
    imem_ack = 1'b1;
    imem_rdata = 32'hFFFF_FFFF;
    stall = 1'b0;
    PC_sel = 2'b00;
    br_taken = 1'b0;
    rs_data = 32'h0;
    step();
    step();
    chk("rst instr", instr, 32'h0);
    chk("rst pc", pc, 32'h0000_3000);
    chk("rst irv", {31'd0, ir_valid}, 32'd0);
    chk("rst instret", instret, 32'h0);
    chk("rst err", {31'd0, err}, 32'd0);
    rst = 1'b0;
    imem_ack = 1'b0;
    chk("rst req", {31'd0, imem_req}, 32'd1);
    chk("rst addr", imem_addr, 32'h0000_3000);

    for (int i = 0; i < 11; i++) run_vec(vecs[i], i);

    // ERR is sticky regardless of ack/stall
    for (int i = 0; i < 3; i++) begin
      imem_ack = 1'b1;
      stall = i[0];
      step();
      chk("err sticky", {31'd0, err}, 32'd1);
      chk("err req", {31'd0, imem_req}, 32'd0);
      chk("err irv", {31'd0, ir_valid}, 32'd0);
      chk("err instret", instret, cnt);
    end
    imem_ack = 1'b0;
    stall = 1'b0;

    rst = 1'b1;
    step();
    rst = 1'b0;
    cnt = 0;
    chk("clr err", {31'd0, err}, 32'd0);
    chk("clr instret", instret, 32'h0);
    chk("clr addr", imem_addr, 32'h0000_3000);
    chk("clr req", {31'd0, imem_req}, 32'd1);

    run_vec(vecs[0], 100);

    // reset mid-fetch at 0x3004, before any ack
    imem_ack = 1'b0;
    step();
    chk("mf req", {31'd0, imem_req}, 32'd1);
    chk("mf addr", imem_addr, 32'h0000_3004);
    rst = 1'b1;
    step();
    rst = 1'b0;
    cnt = 0;
    chk("mf addr_rst", imem_addr, 32'h0000_3000);
    chk("mf irv", {31'd0, ir_valid}, 32'd0);
    chk("mf instret", instret, 32'h0);
    chk("mf req_rst", {31'd0, imem_req}, 32'd1);

    // reset mid-hold must not retire
    imem_ack = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    step();
    imem_ack = 1'b0;
    chk("mh irv", {31'd0, ir_valid}, 32'd1);
    chk("mh instr", instr, 32'hDEAD_BEEF);
    rst = 1'b1;
    stall = 1'b0;
    step();
    rst = 1'b0;
    chk("mh instret", instret, 32'h0);
    chk("mh irv0", {31'd0, ir_valid}, 32'd0);
    chk("mh instr0", instr, 32'h0);
    chk("mh addr", imem_addr, 32'h0000_3000);

    run_vec(vecs[0], 101);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
